// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the fetch stage and `control`.
//   XLEN                    - address/instruction width (RV32I)
//   OP_*                    - major opcode encodings consumed by decode
//   *_LSB/*_MSB/*_BIT       - instruction field bit positions
//   fetch_entry_t           - one buffered instruction: {pc, instr}
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_5_BIT = 30;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory channel between fetch and imem.
//   imem_req_valid/ready/addr  - in-order fetch request (valid/ready)
//   imem_resp_valid/data       - response word, returned in request order
// master: the fetch stage.  slave: the instruction memory.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush.
//   push/push_data  - write (accepted when not full, or full with a pop)
//   pop             - remove head (ignored when empty)
//   flush           - empty the FIFO; wins over push/pop
//   head_data       - current head entry (stale when empty)
//   full/empty/count - occupancy status
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)
                count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding `control`.
//   clk, rst               - clock, synchronous active-high reset
//   imem (master)          - in-order fetch requests / responses
//   redirect_valid/pc      - taken branch/jump: flush and refetch
//   id_valid/ready         - decode handshake on the buffered head
//   id_pc/instr            - head PC and instruction word
//   id_opcode/funct3/funct7_5 - decode fields of id_instr
// XLEN is fixed by riscv_pkg.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_instr,
    output logic [6:0]        id_opcode,
    output logic [2:0]        id_funct3,
    output logic              id_funct7_5
);

    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    // Discard counter: stale responses can pile up across repeated
    // redirects while memory latency is long; 8 bits covers any sane latency.
    localparam int DISC_W = 8;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [DISC_W-1:0] discard_q, discard_d;

    logic              req_fire, resp_keep, pop_raw, id_pop, allowed;
    logic [CNT_W:0]    credit;
    logic [XLEN-1:0]   pcq_head;
    logic [CNT_W-1:0]  outstanding, buf_count;
    logic              pcq_full, pcq_empty, buf_full, buf_empty;
    logic [$bits(fetch_entry_t)-1:0] buf_head_raw;
    fetch_entry_t      buf_head, buf_push;
    logic              unused_flags;

    // Credit counts every slot a non-stale request will eventually need.
    // A pop this cycle frees one slot, so a full credit may still issue.
    assign pop_raw = id_valid && id_ready;
    assign credit  = {1'b0, outstanding} + {1'b0, buf_count};
    assign allowed = (credit < (CNT_W+1)'(BUF_DEPTH)) ||
                     ((credit == (CNT_W+1)'(BUF_DEPTH)) && pop_raw);

    assign imem.imem_req_valid = allowed && !redirect_valid && !rst;
    assign imem.imem_req_addr  = pc_q;

    assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_keep = imem.imem_resp_valid && (discard_q == '0) && !redirect_valid;
    assign id_pop    = pop_raw && !redirect_valid;

    // Addresses of live (non-discarded) requests in issue order; its
    // occupancy is the outstanding count.  Stale requests never enter
    // it after a redirect flush, so its head always matches the next kept word.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_keep),
        .flush     (redirect_valid),
        .head_data (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (outstanding)
    );

    assign buf_push = '{pc: pcq_head, instr: imem.imem_resp_data};

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (buf_push),
        .pop       (id_pop),
        .flush     (redirect_valid),
        .head_data (buf_head_raw),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign unused_flags = &{1'b0, pcq_full, pcq_empty, buf_full};

    // Outputs read zero whenever nothing valid is at the head.
    assign buf_head    = buf_head_raw;
    assign id_valid    = !buf_empty;
    assign id_pc       = id_valid ? buf_head.pc    : '0;
    assign id_instr    = id_valid ? buf_head.instr : '0;
    assign id_opcode   = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct3   = id_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign id_funct7_5 = id_instr[FUNCT7_5_BIT];

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight becomes stale, except a response
            // landing this cycle, which is dropped right now.
            discard_d = discard_q + DISC_W'(outstanding)
                        - DISC_W'(imem.imem_resp_valid);
        end else begin
            if (req_fire)
                pc_d = pc_q + XLEN'(4);
            if (imem.imem_resp_valid && (discard_q != '0))
                discard_d = discard_q - DISC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

endmodule
